// File: rtl/mm_mul_pkg.sv
// Shared types and defaults for the shared-multiplier arbiter.
package mm_mul_pkg;

  localparam int A_W_DEF    = 24;
  localparam int B_W_DEF    = 32;
  localparam int DOUT_W_DEF = 55;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_IDLE  = 2'd2
  } arb_state_e;

  // A single requester still needs a 1-bit tag.
  function automatic int id_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mm_rr_arbiter.sv
// Round-robin arbiter: searches from ptr+1 upward (mod NUM_REQ); ptr moves to the
// granted index only when the grant is actually taken (advance).
module mm_rr_arbiter
  import mm_mul_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = id_width(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               gnt_any
);

  localparam logic [ID_W:0] N_W = (ID_W+1)'(NUM_REQ);

  logic [ID_W-1:0] ptr;
  logic [ID_W:0]   sum;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    gnt_any   = 1'b0;
    sum       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      sum = {1'b0, ptr} + (ID_W+1)'(k);
      if (sum >= N_W) sum = sum - N_W;
      if (!gnt_any && req[sum[ID_W-1:0]]) begin
        gnt_any                  = 1'b1;
        grant[sum[ID_W-1:0]]     = 1'b1;
        grant_idx                = sum[ID_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ptr <= ID_W'(NUM_REQ - 1);
    else if (advance) ptr <= grant_idx;
  end

endmodule

// File: rtl/mm_mul_share_arbiter.sv
// One unsigned A_W x B_W multiplier shared round-robin among NUM_REQ requesters.
// Build option MM_MUL_ARB_OUT_REG_EN adds output stage p2 (latency 2, still 1/cycle).
module mm_mul_share_arbiter
  import mm_mul_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int A_W     = A_W_DEF,
  parameter  int B_W     = B_W_DEF,
  parameter  int DOUT_W  = DOUT_W_DEF,
  localparam int ID_W    = id_width(NUM_REQ)
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*A_W-1:0] req_a,
  input  logic [NUM_REQ*B_W-1:0] req_b,
  input  logic                   drain,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [DOUT_W-1:0]      rsp_data,
  output logic                   idle
);

  // Full-width unsigned product, low DOUT_W bits kept (no saturation).
  function automatic logic [DOUT_W-1:0] mul_trunc(input logic [A_W-1:0] a,
                                                  input logic [B_W-1:0] b);
    logic [A_W+B_W-1:0] a_x;
    logic [A_W+B_W-1:0] b_x;
    a_x = (A_W+B_W)'(a);
    b_x = (A_W+B_W)'(b);
    return DOUT_W'(a_x * b_x);
  endfunction

  arb_state_e        state, state_nxt;
  logic              run_en;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]   grant_idx;
  logic              gnt_any;
  logic              can_accept, accept, pop_p1, pipe_empty;
  logic [A_W-1:0]    a_sel;
  logic [B_W-1:0]    b_sel;

  logic              vld_p1;
  logic [ID_W-1:0]   id_p1;
  logic [A_W-1:0]    a_p1;
  logic [B_W-1:0]    b_p1;

  mm_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk       (ap_clk),
    .rst_n     (ap_rst_n),
    .req       (req_valid),
    .advance   (accept),
    .grant     (grant),
    .grant_idx (grant_idx),
    .gnt_any   (gnt_any)
  );

  assign a_sel = req_a[int'(grant_idx)*A_W +: A_W];
  assign b_sel = req_b[int'(grant_idx)*B_W +: B_W];

  // Ready is gated combinationally so a drain edge blocks the same-cycle accept.
  assign accept    = gnt_any & can_accept & ~drain & run_en & ap_rst_n;
  assign req_ready = grant & {NUM_REQ{accept}};

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state <= ST_RUN;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_RUN:   if (drain) state_nxt = ST_DRAIN;
      ST_DRAIN: if (!drain) state_nxt = ST_RUN;
                else if (pipe_empty) state_nxt = ST_IDLE;
      ST_IDLE:  if (!drain) state_nxt = ST_RUN;
      default:  state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    run_en = (state == ST_RUN);
    idle   = (state == ST_IDLE);
  end

  // ---- stage p1: operand capture ----
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n)   vld_p1 <= 1'b0;
    else if (accept) vld_p1 <= 1'b1;
    else if (pop_p1) vld_p1 <= 1'b0;
  end

  always_ff @(posedge ap_clk) begin
    if (accept) begin
      id_p1 <= grant_idx;
      a_p1  <= a_sel;
      b_p1  <= b_sel;
    end
  end

`ifdef MM_MUL_ARB_OUT_REG_EN
  logic              vld_p2;
  logic [ID_W-1:0]   id_p2;
  logic [DOUT_W-1:0] prod_p2;
  logic              adv_p2;

  assign adv_p2     = ~vld_p2 | rsp_ready;
  assign pop_p1     = adv_p2;
  assign can_accept = ~vld_p1 | adv_p2;
  assign pipe_empty = ~vld_p1 & ~vld_p2;

  // ---- stage p2: registered product ----
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n)   vld_p2 <= 1'b0;
    else if (adv_p2) vld_p2 <= vld_p1;
  end

  always_ff @(posedge ap_clk) begin
    if (adv_p2 && vld_p1) begin
      id_p2   <= id_p1;
      prod_p2 <= mul_trunc(a_p1, b_p1);
    end
  end

  assign rsp_valid = vld_p2;
  assign rsp_id    = vld_p2 ? id_p2   : '0;
  assign rsp_data  = vld_p2 ? prod_p2 : '0;
`else
  assign pop_p1     = rsp_ready;
  assign can_accept = ~vld_p1 | rsp_ready;
  assign pipe_empty = ~vld_p1;

  assign rsp_valid = vld_p1;
  assign rsp_id    = vld_p1 ? id_p1 : '0;
  assign rsp_data  = vld_p1 ? mul_trunc(a_p1, b_p1) : '0;
`endif

endmodule

// File: tb/tb_mm_mul_share_arbiter.sv
// Randomized self-checking bench for mm_mul_share_arbiter against a queue-based model.
module tb_mm_mul_share_arbiter;

  localparam int NUM_REQ = 4;
  localparam int A_W     = 24;
  localparam int B_W     = 32;
  localparam int DOUT_W  = 55;
  localparam int ID_W    = 2;

  logic                   ap_clk = 1'b0;
  logic                   ap_rst_n;
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ*A_W-1:0] req_a;
  logic [NUM_REQ*B_W-1:0] req_b;
  logic                   drain;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [ID_W-1:0]        rsp_id;
  logic [DOUT_W-1:0]      rsp_data;
  logic                   idle;

  always #5 ap_clk = ~ap_clk;

  mm_mul_share_arbiter #(
    .NUM_REQ(NUM_REQ), .A_W(A_W), .B_W(B_W), .DOUT_W(DOUT_W)
  ) dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .drain     (drain),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .idle      (idle)
  );

  typedef struct {
    int                id;
    logic [DOUT_W-1:0] p;
  } rsp_t;

  // Model: in-flight responses in order, round-robin pointer, mode 0=run 1=drain 2=idle.
  rsp_t mq[$];
  int   m_ptr;
  int   m_mode;
  bit   in_rst;

  logic [NUM_REQ-1:0] e_ready;
  bit                 e_vld;
  int                 e_id;
  int                 e_grant;
  logic [DOUT_W-1:0]  e_data;
  bit                 e_idle;

  int n_cmp = 0;
  int n_bad = 0;
  bit refill;
  int last_acc;

  function automatic logic [DOUT_W-1:0] ref_product(input logic [A_W-1:0] a,
                                                    input logic [B_W-1:0] b);
    longint unsigned p;
    p = longint'(a) * longint'(b);
    return p[DOUT_W-1:0];
  endfunction

  function automatic logic [A_W-1:0] pick_a();
    case ($urandom_range(0, 7))
      0:       return '1;
      1:       return '0;
      default: return A_W'($urandom);
    endcase
  endfunction

  function automatic logic [B_W-1:0] pick_b();
    case ($urandom_range(0, 7))
      0:       return '1;
      1:       return '0;
      default: return B_W'($urandom);
    endcase
  endfunction

  task automatic set_operands(input int i, input logic [A_W-1:0] a, input logic [B_W-1:0] b);
    req_a[i*A_W +: A_W] = a;
    req_b[i*B_W +: B_W] = b;
  endtask

  task automatic model_reset();
    mq.delete();
    m_ptr  = NUM_REQ - 1;
    m_mode = 0;
  endtask

  task automatic model_eval();
    int idx;
    e_ready = '0;
    e_grant = -1;
    e_vld   = 1'b0;
    e_id    = 0;
    e_data  = '0;
    e_idle  = 1'b0;
    if (in_rst) return;
    e_vld  = (mq.size() > 0);
    if (e_vld) begin
      e_id   = mq[0].id;
      e_data = mq[0].p;
    end
    e_idle = (m_mode == 2);
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (m_ptr + k) % NUM_REQ;
      if (e_grant < 0 && req_valid[idx]) e_grant = idx;
    end
    if (m_mode == 0 && !drain && (mq.size() == 0 || rsp_ready) && e_grant >= 0)
      e_ready[e_grant] = 1'b1;
  endtask

  task automatic model_clock();
    bit   was_empty;
    int   acc;
    rsp_t r;
    @(posedge ap_clk);
    was_empty = (mq.size() == 0);
    acc = -1;
    if (e_vld && rsp_ready) void'(mq.pop_front());
    if (e_ready != '0) begin
      acc  = e_grant;
      r.id = e_grant;
      r.p  = ref_product(req_a[e_grant*A_W +: A_W], req_b[e_grant*B_W +: B_W]);
      mq.push_back(r);
      m_ptr = e_grant;
    end
    case (m_mode)
      0: if (drain) m_mode = 1;
      1: if (!drain) m_mode = 0; else if (was_empty) m_mode = 2;
      default: if (!drain) m_mode = 0;
    endcase
    @(negedge ap_clk);
    last_acc = acc;
    if (acc >= 0) begin
      req_valid[acc] = 1'b0;
      if (refill) begin
        req_valid[acc] = 1'b1;
        set_operands(acc, pick_a(), pick_b());
      end
    end
  endtask

  task automatic test_reset();
    ap_rst_n  = 1'b0;
    in_rst    = 1'b1;
    drain     = 1'b0;
    rsp_ready = 1'b1;
    refill    = 1'b0;
    req_valid = '1;
    for (int i = 0; i < NUM_REQ; i++) set_operands(i, pick_a(), pick_b());
    model_reset();
    repeat (2) @(negedge ap_clk);
    #1;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    n_cmp++; if (rsp_id !== '0) begin n_bad++; $display("FAIL reset_rsp_id got=%0d exp=0", rsp_id); end
    n_cmp++; if (rsp_data !== '0) begin n_bad++; $display("FAIL reset_rsp_data got=%h exp=0", rsp_data); end
    n_cmp++; if (req_ready !== '0) begin n_bad++; $display("FAIL reset_req_ready got=%b exp=0", req_ready); end
    n_cmp++; if (idle !== 1'b0) begin n_bad++; $display("FAIL reset_idle got=%b exp=0", idle); end
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    in_rst   = 1'b0;
  endtask

  task automatic test_rr_order();
    int exp_ord[5] = '{0, 1, 2, 3, 0};
    int got_n = 0;
    refill    = 1'b1;
    rsp_ready = 1'b1;
    for (int c = 0; c < 17; c++) begin
      if (c == 7) refill = 1'b0;
      if (c >= 7 && req_valid == '0 && mq.size() == 0) break;
      #1; model_eval();
      n_cmp++; if (req_ready !== e_ready) begin n_bad++; $display("FAIL rr_req_ready cyc=%0d got=%b exp=%b", c, req_ready, e_ready); end
      n_cmp++; if (rsp_valid !== e_vld) begin n_bad++; $display("FAIL rr_rsp_valid cyc=%0d got=%b exp=%b", c, rsp_valid, e_vld); end
      if (e_vld) begin
        n_cmp++;
        if (int'(rsp_id) != e_id || rsp_data !== e_data) begin
          n_bad++; $display("FAIL rr_rsp cyc=%0d got id=%0d data=%h exp id=%0d data=%h", c, rsp_id, rsp_data, e_id, e_data);
        end
      end
      if (rsp_valid && got_n < 5) begin
        n_cmp++;
        if (int'(rsp_id) != exp_ord[got_n]) begin n_bad++; $display("FAIL rr_order n=%0d got=%0d exp=%0d", got_n, rsp_id, exp_ord[got_n]); end
        got_n++;
      end
      model_clock();
    end
    n_cmp++; if (got_n != 5) begin n_bad++; $display("FAIL rr_count got=%0d exp=5", got_n); end
  endtask

  task automatic test_max_operands();
    logic [DOUT_W-1:0] want;
    bit seen = 1'b0;
    want = 55'h7FFFFEFF000001;
    refill    = 1'b0;
    rsp_ready = 1'b1;
    req_valid[2] = 1'b1;
    set_operands(2, 24'hFFFFFF, 32'hFFFFFFFF);
    for (int c = 0; c < 4; c++) begin
      #1; model_eval();
      n_cmp++; if (req_ready !== e_ready) begin n_bad++; $display("FAIL max_req_ready cyc=%0d got=%b exp=%b", c, req_ready, e_ready); end
      n_cmp++; if (rsp_valid !== e_vld) begin n_bad++; $display("FAIL max_rsp_valid cyc=%0d got=%b exp=%b", c, rsp_valid, e_vld); end
      if (rsp_valid && !seen) begin
        seen = 1'b1;
        n_cmp++;
        if (rsp_id !== 2'd2 || rsp_data !== want) begin
          n_bad++; $display("FAIL max_product got id=%0d data=%h exp id=2 data=%h", rsp_id, rsp_data, want);
        end
      end
      model_clock();
    end
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL max_timeout got=none exp=one response"); end
  endtask

  task automatic test_backpressure();
    logic [ID_W-1:0]   hold_id;
    logic [DOUT_W-1:0] hold_data;
    refill    = 1'b1;
    req_valid = '1;
    for (int i = 0; i < NUM_REQ; i++) set_operands(i, pick_a(), pick_b());
    for (int c = 0; c < 22; c++) begin
      rsp_ready = !(c >= 2 && c < 7);
      if (c == 13) refill = 1'b0;
      if (c >= 13 && req_valid == '0 && mq.size() == 0) break;
      #1; model_eval();
      if (c == 2) begin hold_id = rsp_id; hold_data = rsp_data; end
      if (c > 2 && c < 7) begin
        n_cmp++;
        if (rsp_id !== hold_id || rsp_data !== hold_data || req_ready !== '0) begin
          n_bad++; $display("FAIL bp_hold cyc=%0d got id=%0d data=%h rdy=%b exp id=%0d data=%h rdy=0", c, rsp_id, rsp_data, req_ready, hold_id, hold_data);
        end
      end
      n_cmp++; if (req_ready !== e_ready) begin n_bad++; $display("FAIL bp_req_ready cyc=%0d got=%b exp=%b", c, req_ready, e_ready); end
      n_cmp++; if (rsp_valid !== e_vld) begin n_bad++; $display("FAIL bp_rsp_valid cyc=%0d got=%b exp=%b", c, rsp_valid, e_vld); end
      if (e_vld) begin
        n_cmp++;
        if (int'(rsp_id) != e_id || rsp_data !== e_data) begin
          n_bad++; $display("FAIL bp_rsp cyc=%0d got id=%0d data=%h exp id=%0d data=%h", c, rsp_id, rsp_data, e_id, e_data);
        end
      end
      model_clock();
    end
    rsp_ready = 1'b1;
  endtask

  task automatic test_single_req();
    int acc_cnt = 0;
    refill    = 1'b1;
    rsp_ready = 1'b1;
    req_valid = 4'b1000;
    set_operands(3, pick_a(), pick_b());
    for (int c = 0; c < 10; c++) begin
      #1; model_eval();
      if (req_ready[3]) acc_cnt++;
      n_cmp++; if (req_ready !== e_ready) begin n_bad++; $display("FAIL single_req_ready cyc=%0d got=%b exp=%b", c, req_ready, e_ready); end
      if (e_vld) begin
        n_cmp++;
        if (rsp_valid !== 1'b1 || int'(rsp_id) != e_id || rsp_data !== e_data) begin
          n_bad++; $display("FAIL single_rsp cyc=%0d got v=%b id=%0d data=%h exp id=%0d data=%h", c, rsp_valid, rsp_id, rsp_data, e_id, e_data);
        end
      end
      model_clock();
    end
    n_cmp++; if (acc_cnt != 10) begin n_bad++; $display("FAIL single_accepts got=%0d exp=10", acc_cnt); end
    refill    = 1'b0;
    req_valid = '1;
    for (int i = 0; i < 3; i++) set_operands(i, pick_a(), pick_b());
    #1; model_eval();
    n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL single_next_grant got=%b exp=0001", req_ready); end
    model_clock();
  endtask

  task automatic test_drain();
    int idle_at = -1;
    refill    = 1'b1;
    rsp_ready = 1'b1;
    req_valid = '1;
    for (int i = 0; i < NUM_REQ; i++) set_operands(i, pick_a(), pick_b());
    for (int c = -2; c < 10; c++) begin
      drain = (c >= 0 && c < 6);
      #1; model_eval();
      if (c == 0) begin
        n_cmp++; if (req_ready !== '0) begin n_bad++; $display("FAIL drain_gate got=%b exp=0", req_ready); end
      end
      if (idle && idle_at < 0) idle_at = c;
      if (c == 6) begin
        n_cmp++; if (req_ready !== '0) begin n_bad++; $display("FAIL drain_exit_same got=%b exp=0", req_ready); end
      end
      if (c == 7) begin
        n_cmp++; if (req_ready === '0) begin n_bad++; $display("FAIL drain_resume got=%b exp=nonzero", req_ready); end
      end
      n_cmp++; if (req_ready !== e_ready) begin n_bad++; $display("FAIL drain_req_ready cyc=%0d got=%b exp=%b", c, req_ready, e_ready); end
      n_cmp++; if (idle !== e_idle) begin n_bad++; $display("FAIL drain_idle cyc=%0d got=%b exp=%b", c, idle, e_idle); end
      n_cmp++; if (rsp_valid !== e_vld) begin n_bad++; $display("FAIL drain_rsp_valid cyc=%0d got=%b exp=%b", c, rsp_valid, e_vld); end
      if (e_vld) begin
        n_cmp++;
        if (int'(rsp_id) != e_id || rsp_data !== e_data) begin
          n_bad++; $display("FAIL drain_rsp cyc=%0d got id=%0d data=%h exp id=%0d data=%h", c, rsp_id, rsp_data, e_id, e_data);
        end
      end
      model_clock();
    end
    n_cmp++; if (idle_at != 2) begin n_bad++; $display("FAIL drain_idle_time got=%0d exp=2", idle_at); end
    drain = 1'b0;
  endtask

  task automatic test_reset_midflight();
    bit seen = 1'b0;
    refill    = 1'b0;
    rsp_ready = 1'b0;
    req_valid = '1;
    for (int i = 0; i < NUM_REQ; i++) set_operands(i, pick_a(), pick_b());
    for (int c = 0; c < 3; c++) begin
      #1; model_eval();
      n_cmp++; if (rsp_valid !== e_vld) begin n_bad++; $display("FAIL mid_pre_valid cyc=%0d got=%b exp=%b", c, rsp_valid, e_vld); end
      model_clock();
    end
    req_valid = '1;
    ap_rst_n  = 1'b0;
    in_rst    = 1'b1;
    model_reset();
    #1;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL mid_reset_valid got=%b exp=0", rsp_valid); end
    @(negedge ap_clk);
    ap_rst_n  = 1'b1;
    in_rst    = 1'b0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1; model_eval();
      if (rsp_valid && !seen) begin
        seen = 1'b1;
        n_cmp++; if (rsp_id !== '0) begin n_bad++; $display("FAIL mid_first_id got=%0d exp=0", rsp_id); end
      end
      n_cmp++; if (rsp_valid !== e_vld) begin n_bad++; $display("FAIL mid_rsp_valid cyc=%0d got=%b exp=%b", c, rsp_valid, e_vld); end
      n_cmp++; if (req_ready !== e_ready) begin n_bad++; $display("FAIL mid_req_ready cyc=%0d got=%b exp=%b", c, req_ready, e_ready); end
      if (e_vld) begin
        n_cmp++;
        if (int'(rsp_id) != e_id || rsp_data !== e_data) begin
          n_bad++; $display("FAIL mid_rsp cyc=%0d got id=%0d data=%h exp id=%0d data=%h", c, rsp_id, rsp_data, e_id, e_data);
        end
      end
      model_clock();
    end
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL mid_timeout got=none exp=response"); end
  endtask

  task automatic test_random();
    refill = 1'b0;
    for (int c = 0; c < 400; c++) begin
      rsp_ready = ($urandom_range(0, 99) < 70);
      if ($urandom_range(0, 99) < 4) drain = ~drain;
      if (c >= 380) drain = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 99) < 40) begin
          req_valid[i] = 1'b1;
          set_operands(i, pick_a(), pick_b());
        end
      end
      #1; model_eval();
      n_cmp++; if (req_ready !== e_ready) begin n_bad++; $display("FAIL rnd_req_ready cyc=%0d got=%b exp=%b", c, req_ready, e_ready); end
      n_cmp++; if (rsp_valid !== e_vld) begin n_bad++; $display("FAIL rnd_rsp_valid cyc=%0d got=%b exp=%b", c, rsp_valid, e_vld); end
      n_cmp++; if (idle !== e_idle) begin n_bad++; $display("FAIL rnd_idle cyc=%0d got=%b exp=%b", c, idle, e_idle); end
      if (e_vld) begin
        n_cmp++;
        if (int'(rsp_id) != e_id || rsp_data !== e_data) begin
          n_bad++; $display("FAIL rnd_rsp cyc=%0d got id=%0d data=%h exp id=%0d data=%h", c, rsp_id, rsp_data, e_id, e_data);
        end
      end
      model_clock();
    end
  endtask

  initial begin
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    last_acc  = -1;
    @(negedge ap_clk);
    test_reset();
    test_rr_order();
    test_max_operands();
    test_backpressure();
    test_single_req();
    test_drain();
    test_reset_midflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
